// File: rtl/enc16_4_scan.sv
// Sequential 16-to-4 encoder: accepts a request vector and emits the index of each set bit, one per beat.
// Build option ENC_MSB_FIRST_EN reverses the scan order (highest set bit first).
module enc16_4_scan #(
  parameter int WIDTH = 16,
  parameter int IDXW  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             En,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] D,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDXW-1:0]  W,
  output logic             last,
  output logic             none,
  output logic [IDXW:0]    cnt
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t           state;
  logic [WIDTH-1:0] p;
  logic [IDXW:0]    cnt_q;
  logic             z;
  logic [IDXW-1:0]  w_q;
  logic             last_q;
  logic [WIDTH-1:0] pick;
  logic [WIDTH-1:0] p_next;

  // Index of the bit that is emitted next from vector v (0 when v is empty).
  function automatic logic [IDXW-1:0] scan_idx(input logic [WIDTH-1:0] v);
    logic [IDXW-1:0] idx;
    idx = '0;
`ifdef ENC_MSB_FIRST_EN
    for (int i = 0; i < WIDTH; i++)
      if (v[i]) idx = IDXW'(i);
`else
    for (int i = WIDTH - 1; i >= 0; i--)
      if (v[i]) idx = IDXW'(i);
`endif
    return idx;
  endfunction

  function automatic logic [IDXW:0] popcount(input logic [WIDTH-1:0] v);
    logic [IDXW:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++)
      c += {{IDXW{1'b0}}, v[i]};
    return c;
  endfunction

  function automatic logic at_most_one(input logic [WIDTH-1:0] v);
    return (v & (v - WIDTH'(1))) == '0;
  endfunction

  assign pick   = WIDTH'(1) << w_q;
  assign p_next = p & ~pick;

  assign in_ready  = !rst && En && (state == IDLE);
  assign out_valid = !rst && (state == EMIT);
  assign W         = out_valid ? w_q : '0;
  assign last      = out_valid && last_q;
  assign none      = out_valid && z;
  assign cnt       = cnt_q;

  // Beat registers are precomputed one step ahead so outputs never depend on
  // the live handshake inputs and hold steady through back-pressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      p      <= '0;
      cnt_q  <= '0;
      z      <= 1'b0;
      w_q    <= '0;
      last_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            p      <= D;
            cnt_q  <= popcount(D);
            z      <= (D == '0);
            w_q    <= scan_idx(D);
            last_q <= at_most_one(D);
            state  <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (last_q) begin
              state  <= IDLE;
              p      <= '0;
              z      <= 1'b0;
              w_q    <= '0;
              last_q <= 1'b0;
            end else begin
              p      <= p_next;
              w_q    <= scan_idx(p_next);
              last_q <= at_most_one(p_next);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_enc16_4_scan.sv
// Self-checking bench for enc16_4_scan: vector table, corner sequences, loopback decode and random traffic.
module tb_enc16_4_scan;

  logic        clk = 1'b0;
  logic        rst, En, in_valid, in_ready, out_valid, out_ready, last, none;
  logic [15:0] D;
  logic [3:0]  W;
  logic [4:0]  cnt;

  always #5 clk = ~clk;

  enc16_4_scan dut (
    .clk(clk), .rst(rst), .En(En), .in_valid(in_valid), .in_ready(in_ready),
    .D(D), .out_valid(out_valid), .out_ready(out_ready), .W(W), .last(last),
    .none(none), .cnt(cnt)
  );

  typedef struct packed {logic [3:0] w; logic last; logic none;} beat_t;
  typedef struct packed {logic [3:0] w; logic last; logic none; logic [4:0] cnt;} cap_t;
  typedef struct {
    logic [15:0] d;
    int          nbeats;
    logic [3:0]  first_w;
    logic [3:0]  final_w;
    logic [4:0]  cnt;
    logic        none;
  } vec_t;

  beat_t      expq[$];
  cap_t       cap[$];
  bit         busy = 0;
  bit         accepted = 0;
  bit         rand_rdy = 0;
  logic [4:0] exp_cnt;
  int         n_cmp = 0;
  int         n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] dec4_16(input logic [3:0] idx);
    return 16'h0001 << idx;
  endfunction

  // Reference: the beats of a vector are its set-bit indices in scan order.
  function automatic void load_model(input logic [15:0] d);
    beat_t b;
    int    n, seen;
    expq.delete();
    n = $countones(d);
    exp_cnt = 5'(n);
    if (n == 0) begin
      b.w = 4'd0; b.last = 1'b1; b.none = 1'b1;
      expq.push_back(b);
    end else begin
      seen = 0;
      for (int k = 0; k < 16; k++) begin
        int i;
`ifdef ENC_MSB_FIRST_EN
        i = 15 - k;
`else
        i = k;
`endif
        if (d[i]) begin
          seen++;
          b.w = 4'(i); b.last = (seen == n); b.none = 1'b0;
          expq.push_back(b);
        end
      end
    end
  endfunction

  task automatic tick();
    bit   exp_rdy, exp_ov;
    cap_t c;
    #1;
    exp_rdy = !rst && En && !busy;
    exp_ov  = busy && !rst;
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, exp_ov);
    if (exp_ov && expq.size() > 0) begin
      chk("W", W, expq[0].w);
      chk("last", last, expq[0].last);
      chk("none", none, expq[0].none);
      chk("cnt", cnt, exp_cnt);
      if (!expq[0].none) chk("loop_Y", dec4_16(W), 16'h0001 << expq[0].w);
    end else if (!exp_ov) begin
      chk("idle_W", W, 0);
      chk("idle_last", last, 0);
      chk("idle_none", none, 0);
    end
    accepted = 0;
    if (rst) begin
      busy = 0;
      expq.delete();
    end else if (in_valid && exp_rdy) begin
      load_model(D);
      busy = 1;
      accepted = 1;
    end else if (exp_ov && out_ready) begin
      c.w = W; c.last = last; c.none = none; c.cnt = cnt;
      cap.push_back(c);
      void'(expq.pop_front());
      if (expq.size() == 0) busy = 0;
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int t;
    for (t = 0; t < 300 && busy; t++) begin
      if (rand_rdy) begin
        out_ready = 1'($urandom_range(0, 1));
        En        = 1'($urandom_range(0, 1));
      end
      tick();
    end
    if (busy) chk("drain_timeout", 1, 0);
  endtask

  task automatic send(input logic [15:0] d, input bit wait_drain);
    int t;
    D = d;
    in_valid = 1'b1;
    accepted = 0;
    for (t = 0; t < 50 && !accepted; t++) tick();
    if (!accepted) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
    if (wait_drain) drain();
  endtask

  vec_t tbl[6];

  initial begin
`ifdef ENC_MSB_FIRST_EN
    tbl[0] = '{16'h0010, 1,  4'd4,  4'd4, 5'd1,  1'b0};
    tbl[1] = '{16'h8421, 4,  4'd15, 4'd0, 5'd4,  1'b0};
    tbl[2] = '{16'h0000, 1,  4'd0,  4'd0, 5'd0,  1'b1};
    tbl[3] = '{16'hFFFF, 16, 4'd15, 4'd0, 5'd16, 1'b0};
    tbl[4] = '{16'h0006, 2,  4'd2,  4'd1, 5'd2,  1'b0};
    tbl[5] = '{16'h8001, 2,  4'd15, 4'd0, 5'd2,  1'b0};
`else
    tbl[0] = '{16'h0010, 1,  4'd4,  4'd4,  5'd1,  1'b0};
    tbl[1] = '{16'h8421, 4,  4'd0,  4'd15, 5'd4,  1'b0};
    tbl[2] = '{16'h0000, 1,  4'd0,  4'd0,  5'd0,  1'b1};
    tbl[3] = '{16'hFFFF, 16, 4'd0,  4'd15, 5'd16, 1'b0};
    tbl[4] = '{16'h0006, 2,  4'd1,  4'd2,  5'd2,  1'b0};
    tbl[5] = '{16'h8001, 2,  4'd0,  4'd15, 5'd2,  1'b0};
`endif

    rst = 1'b1; En = 1'b1; in_valid = 1'b0; out_ready = 1'b0; D = '0;
    @(negedge clk);
    tick();
    tick();
    chk("cnt_reset", cnt, 0);
    rst = 1'b0;
    tick();

    out_ready = 1'b1;
    foreach (tbl[i]) begin
      cap.delete();
      send(tbl[i].d, 1);
      tick();
      chk($sformatf("tbl%0d_nbeats", i), cap.size(), tbl[i].nbeats);
      if (cap.size() == tbl[i].nbeats) begin
        chk($sformatf("tbl%0d_first_w", i), cap[0].w, tbl[i].first_w);
        chk($sformatf("tbl%0d_final_w", i), cap[cap.size()-1].w, tbl[i].final_w);
        chk($sformatf("tbl%0d_final_last", i), cap[cap.size()-1].last, 1);
        chk($sformatf("tbl%0d_none", i), cap[0].none, tbl[i].none);
        for (int j = 0; j < cap.size(); j++)
          chk($sformatf("tbl%0d_cnt", i), cap[j].cnt, tbl[i].cnt);
        for (int j = 0; j + 1 < cap.size(); j++)
          chk($sformatf("tbl%0d_early_last", i), cap[j].last, 0);
      end
    end

    // Back-pressure with En dropped while draining.
    cap.delete();
    out_ready = 1'b0;
    send(16'h0006, 0);
    En = 1'b0;
    repeat (3) tick();
    out_ready = 1'b1;
    drain();
    En = 1'b1;
    tick();
    chk("stall_nbeats", cap.size(), 2);
`ifdef ENC_MSB_FIRST_EN
    if (cap.size() == 2) begin chk("stall_w0", cap[0].w, 2); chk("stall_w1", cap[1].w, 1); end
`else
    if (cap.size() == 2) begin chk("stall_w0", cap[0].w, 1); chk("stall_w1", cap[1].w, 2); end
`endif

    // Reset in the middle of a 16-beat vector.
    cap.delete();
    out_ready = 1'b1;
    send(16'hFFFF, 0);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    tick();
    chk("mid_rst_beats", cap.size(), 3);
    rst = 1'b0;
    repeat (6) tick();
    chk("post_rst_no_stale", cap.size(), 3);

    // Loopback: all single-bit vectors back-to-back with in_valid held high.
    cap.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      int t;
      D = 16'h0001 << i;
      in_valid = 1'b1;
      accepted = 0;
      for (t = 0; t < 20 && !accepted; t++) tick();
      if (!accepted) chk("b2b_accept_timeout", 0, 1);
    end
    in_valid = 1'b0;
    drain();
    chk("b2b_nbeats", cap.size(), 16);
    if (cap.size() == 16)
      for (int i = 0; i < 16; i++) chk($sformatf("b2b_Y%0d", i), dec4_16(cap[i].w), 16'h0001 << i);

    // Random traffic with random back-pressure and enable.
    rand_rdy = 1;
    for (int n = 0; n < 60; n++) begin
      logic [15:0] d;
      case ($urandom_range(0, 3))
        0:       d = 16'h0000;
        1:       d = 16'h0001 << $urandom_range(0, 15);
        default: d = 16'($urandom);
      endcase
      En = 1'b1;
      out_ready = 1'($urandom_range(0, 1));
      send(d, 1);
      repeat ($urandom_range(0, 2)) begin
        out_ready = 1'($urandom_range(0, 1));
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
